// File: rtl/sample_assembler.sv
// Packs a UART byte stream into multi-channel signed sample frames with a
// double-buffered output. Optional inter-byte timeout: SAMPLE_ASSEMBLER_TIMEOUT_EN.
module sample_assembler #(
    parameter int WIDTH          = 16,
    parameter int CHANNELS       = 2,
    parameter int BIG_ENDIAN     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_i,
    input  logic [7:0]                          data_uart_i,
    input  logic                                data_valid_i,
    input  logic                                ready_i,
    output logic signed [CHANNELS*WIDTH-1:0]    data_o,
    output logic                                merge_finished_o,
    output logic                                overrun_o,
    output logic                                sync_err_o
);

    localparam int FW  = CHANNELS * WIDTH;
    localparam int BPC = WIDTH / 8;
    localparam int NB  = FW / 8;
    localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    // Handshake: a byte is taken on any edge where start_i && data_valid_i;
    // a frame is handed off on any edge where merge_finished_o && ready_i.
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   asm_q, asm_d;
    logic [FW-1:0]   data_q, data_d;
    logic            overrun_q, overrun_d;
    logic [FW-1:0]   wr_mask;
    logic [FW-1:0]   frame;
    logic            accept;
    logic            frame_done;
    logic            timeout;

    assign accept     = start_i && data_valid_i;
    assign frame_done = accept && (cnt_q == LAST);

    // Byte count j maps to a fixed byte lane of the frame; the mapping is a
    // permutation so each mask byte has exactly one driver.
    for (genvar j = 0; j < NB; j++) begin : g_lane
        localparam int CH   = j / BPC;
        localparam int K    = j % BPC;
        localparam int LANE = (CHANNELS - 1 - CH) * BPC + ((BIG_ENDIAN != 0) ? (BPC - 1 - K) : K);
        assign wr_mask[LANE*8 +: 8] = {8{accept && (cnt_q == CW'(j))}};
    end

    assign frame = (asm_q & ~wr_mask) | ({NB{data_uart_i}} & wr_mask);

`ifdef SAMPLE_ASSEMBLER_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    logic [GW-1:0] gap_q, gap_d;
    logic          sync_q;

    always_comb begin
        gap_d   = '0;
        timeout = 1'b0;
        if (!accept && (cnt_q != '0)) begin
            if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            gap_q  <= gap_d;
            sync_q <= timeout;
        end
    end

    assign sync_err_o = sync_q;
`else
    assign timeout    = 1'b0;
    assign sync_err_o = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (timeout) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = frame_done ? '0 : cnt_q + 1'b1;
        end
    end

    // The assembly register restarts empty after a completed or dropped frame.
    assign asm_d = (timeout || frame_done) ? '0 : frame;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        case (state_q)
            COLLECT: begin
                if (frame_done) begin
                    data_d  = frame;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (frame_done) begin
                    if (ready_i) begin
                        data_d = frame;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (ready_i) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            asm_q     <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o           = data_q;
    assign merge_finished_o = (state_q == HOLD);
    assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_sample_assembler.sv
// Bench for sample_assembler: three parameterisations share one byte stream and
// are compared every cycle against a queue-based frame model.
module tb_sample_assembler;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  din = 8'h00;

    logic [31:0] d0, d1, d2;
    logic        v0, v1, v2, o0, o1, o2, s0, s1, s2;

    always #5 clk = ~clk;

    sample_assembler #(.WIDTH(16), .CHANNELS(2), .BIG_ENDIAN(1), .TIMEOUT_CYCLES(TO)) u_be (
        .clk(clk), .rst(rst), .start_i(start), .data_uart_i(din), .data_valid_i(valid),
        .ready_i(ready), .data_o(d0), .merge_finished_o(v0), .overrun_o(o0), .sync_err_o(s0));

    sample_assembler #(.WIDTH(16), .CHANNELS(2), .BIG_ENDIAN(0), .TIMEOUT_CYCLES(TO)) u_le (
        .clk(clk), .rst(rst), .start_i(start), .data_uart_i(din), .data_valid_i(valid),
        .ready_i(ready), .data_o(d1), .merge_finished_o(v1), .overrun_o(o1), .sync_err_o(s1));

    sample_assembler #(.WIDTH(8), .CHANNELS(4), .BIG_ENDIAN(1), .TIMEOUT_CYCLES(TO)) u_c4 (
        .clk(clk), .rst(rst), .start_i(start), .data_uart_i(din), .data_valid_i(valid),
        .ready_i(ready), .data_o(d2), .merge_finished_o(v2), .overrun_o(o2), .sync_err_o(s2));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: bytes of the frame in progress, one pending output frame.
    logic [7:0]  m_bytes[$];
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;
    bit          m_sync  = 1'b0;
    logic [31:0] m_frame[3];
    int          m_gap   = 0;

    function automatic logic [31:0] pack(input logic [7:0] b[$], input int w, input int ch, input bit be);
        logic [63:0] f;
        logic [63:0] v;
        int          bpc;
        f   = '0;
        bpc = w / 8;
        for (int c = 0; c < ch; c++) begin
            v = '0;
            for (int k = 0; k < bpc; k++) begin
                if (be) v = (v << 8) | 64'(b[c*bpc + k]);
                else    v = v | (64'(b[c*bpc + k]) << (8 * k));
            end
            f = (f << w) | v;
        end
        return f[31:0];
    endfunction

    task automatic model_step();
        logic [31:0] nf[3];
        bit          done;
        done   = 1'b0;
        m_sync = 1'b0;
        if (rst) begin
            m_bytes.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_gap   = 0;
            for (int i = 0; i < 3; i++) m_frame[i] = '0;
            return;
        end
        if (start && valid) begin
            m_bytes.push_back(din);
            m_gap = 0;
            if (m_bytes.size() == 4) begin
                nf[0] = pack(m_bytes, 16, 2, 1'b1);
                nf[1] = pack(m_bytes, 16, 2, 1'b0);
                nf[2] = pack(m_bytes, 8, 4, 1'b1);
                m_bytes.delete();
                done = 1'b1;
            end
        end else if (m_bytes.size() != 0) begin
            m_gap++;
`ifdef SAMPLE_ASSEMBLER_TIMEOUT_EN
            if (m_gap == TO) begin
                m_bytes.delete();
                m_gap  = 0;
                m_sync = 1'b1;
            end
`endif
        end
        if (m_valid) begin
            if (ready) begin
                m_valid = done;
                if (done) m_frame = nf;
            end else if (done) begin
                m_ovr = 1'b1;
            end
        end else if (done) begin
            m_valid = 1'b1;
            m_frame = nf;
        end
    endtask

    task automatic compare();
        check("data_be", d0, m_frame[0]);
        check("data_le", d1, m_frame[1]);
        check("data_c4", d2, m_frame[2]);
        check("valid_be", v0, m_valid);
        check("valid_le", v1, m_valid);
        check("valid_c4", v2, m_valid);
        check("ovr_be", o0, m_ovr);
        check("ovr_le", o1, m_ovr);
        check("ovr_c4", o2, m_ovr);
        check("sync_be", s0, m_sync);
        check("sync_le", s1, m_sync);
        check("sync_c4", s2, m_sync);
    endtask

    task automatic step(input bit r, input bit s, input bit v, input bit rd, input logic [7:0] d);
        rst   = r;
        start = s;
        valid = v;
        ready = rd;
        din   = d;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic send(input logic [7:0] b, input bit rd);
        step(1'b0, 1'b1, 1'b1, rd, b);
    endtask

    task automatic idle(input bit rd);
        step(1'b0, 1'b1, 1'b0, rd, 8'($urandom));
    endtask

    int pulses;

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        check("rst_data", d0, 32'h0);
        check("rst_valid", v0, 1'b0);
        check("rst_ovr", o0, 1'b0);
        check("rst_sync", s0, 1'b0);

        // Basic frame, both byte orders, 8-bit channels.
        send(8'h12, 1'b1); send(8'h34, 1'b1); send(8'h56, 1'b1);
        check("pre_valid", v0, 1'b0);
        send(8'h78, 1'b1);
        check("basic_valid", v0, 1'b1);
        check("basic_be", d0, 32'h12345678);
        check("basic_le", d1, 32'h34127856);
        check("basic_c4", d2, 32'h12345678);
        idle(1'b1);
        check("basic_pulse", v0, 1'b0);

        // Output held while downstream stalls; second frame is dropped.
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        check("ovr_hold", d0, 32'h01020304);
        check("ovr_flag", o0, 1'b1);
        check("ovr_valid", v0, 1'b1);
        idle(1'b1);
        check("ovr_drop", v0, 1'b0);

        // Reset mid-frame leaves no stale bytes.
        send(8'h55, 1'b1); send(8'h66, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        send(8'hAA, 1'b1); send(8'hBB, 1'b1); send(8'hCC, 1'b1); send(8'hDD, 1'b1);
        check("rst_mid", d0, 32'hAABBCCDD);
        check("rst_mid_ovr", o0, 1'b0);
        idle(1'b1);

        // New frame completes on the same edge the pending one is taken.
        send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
        send(8'hD1, 1'b0); send(8'hD2, 1'b0); send(8'hD3, 1'b0);
        check("swap_old", d0, 32'hC1C2C3C4);
        send(8'hD4, 1'b1);
        check("swap_valid", v0, 1'b1);
        check("swap_data", d0, 32'hD1D2D3D4);
        check("swap_ovr", o0, 1'b0);
        idle(1'b1);
        check("swap_drop", v0, 1'b0);

        // start_i low mid-frame pauses collection.
        send(8'h11, 1'b1); send(8'h22, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
        send(8'h33, 1'b1); send(8'h44, 1'b1);
        check("pause", d0, 32'h11223344);
        idle(1'b1);

        // Valid gaps of 0..3 cycles between bytes.
        send(8'h80, 1'b1);
        idle(1'b1); send(8'h7F, 1'b1);
        idle(1'b1); idle(1'b1); send(8'h00, 1'b1);
        idle(1'b1); idle(1'b1); idle(1'b1); send(8'hFF, 1'b1);
        check("gaps_c4", d2, 32'h807F00FF);
        check("gaps_be", d0, 32'h807F00FF);
        idle(1'b1);

        pulses = 0;
        send(8'hA1, 1'b1); send(8'hA2, 1'b1); send(8'hA3, 1'b1);
        for (int i = 0; i < TO + 4; i++) begin
            idle(1'b1);
            pulses += int'(s0);
        end
`ifdef SAMPLE_ASSEMBLER_TIMEOUT_EN
        check("timeout_pulses", pulses, 1);
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
        check("timeout_next", d0, 32'h11223344);
`else
        check("no_timeout_pulses", pulses, 0);
        send(8'h44, 1'b1);
        check("no_timeout_frame", d0, 32'hA1A2A344);
`endif
        idle(1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_assembler.md
SAMPLE_ASSEMBLER -- requirements
Module: sample_assembler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving bits per channel sample (multiple of 8, 8..32).
REQ-002 The block SHALL have parameter CHANNELS, default 2, giving channels per frame (1..4); channel 0 is I, channel 1 is Q.
REQ-003 The block SHALL have parameter BIG_ENDIAN, default 1, where 1 means the MS byte of each channel arrives first and 0 means the LS byte arrives first.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum inter-byte gap in clk cycles (used only under REQ-024).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port start_i, input, 1 bit: enable; bytes are accepted only while high.
REQ-008 The block SHALL have port data_uart_i, input, 8 bits: received UART byte.
REQ-009 The block SHALL have port data_valid_i, input, 1 bit: data_uart_i is valid this cycle.
REQ-010 The block SHALL have port ready_i, input, 1 bit: downstream accepts the frame.
REQ-011 The block SHALL have port data_o, output, CHANNELS*WIDTH bits, signed: the assembled frame; channel 0 is in the top WIDTH bits and channel k in bits [(CHANNELS-k)*WIDTH-1 -: WIDTH].
REQ-012 The block SHALL have port merge_finished_o, output, 1 bit: frame valid.
REQ-013 The block SHALL have port overrun_o, output, 1 bit: sticky flag, set when a frame is dropped.
REQ-014 The block SHALL have port sync_err_o, output, 1 bit: one-cycle pulse when a partial frame is discarded.

Function
REQ-015 The block SHALL accept a byte on a cycle only when start_i=1 and data_valid_i=1; NB = CHANNELS*WIDTH/8 bytes form one frame.
REQ-016 A byte counter (0..NB-1) SHALL select the destination byte lane; byte j belongs to channel j/(WIDTH/8) and is placed MS-first within the channel when BIG_ENDIAN=1, LS-first when BIG_ENDIAN=0.
REQ-017 The FSM SHALL have the states COLLECT and HOLD: COLLECT stores bytes into a shift/assembly register; on acceptance of byte NB-1 the counter wraps to 0 and the frame moves to the output register.
REQ-018 data_o and merge_finished_o=1 SHALL appear on the cycle after byte NB-1 is accepted (latency 1), and the FSM enters HOLD.
REQ-019 In HOLD, merge_finished_o and data_o SHALL stay stable until a cycle with ready_i=1; the valid signal drops on the following cycle unless a new frame is transferred on that same edge.
REQ-020 Collection SHALL continue during HOLD (double buffer); a frame that completes while the output is still unaccepted SHALL be discarded, overrun_o SHALL be set, and the pending output SHALL be kept.
REQ-021 If the new frame completes on the same edge on which ready_i=1 empties HOLD, the block SHALL transfer it without overrun, and merge_finished_o SHALL remain 1 continuously.
REQ-022 When start_i falls mid-frame, the partial frame and counter SHALL be retained; collection resumes when start_i returns.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL clear the counter, the assembly register and data_o to 0, set merge_finished_o, overrun_o and sync_err_o to 0, and enter COLLECT; a reset in mid-frame discards the partial bytes, and reset takes priority over all other inputs.

Configuration
REQ-024 With macro SAMPLE_ASSEMBLER_TIMEOUT_EN defined, a gap counter SHALL count cycles since the last accepted byte while the counter is non-zero; when the count reaches TIMEOUT_CYCLES, the block SHALL reset the counter to 0, drop the partial frame and pulse sync_err_o for one cycle. Without the macro, no gap counter SHALL exist and sync_err_o SHALL be tied to 0.

Verification
REQ-025 WIDTH=16, CHANNELS=2, BIG_ENDIAN=1, ready_i=1, bytes 0x12,0x34,0x56,0x78 -> data_o=0x12345678 and merge_finished_o high for exactly 1 cycle, 1 cycle after the last byte.
REQ-026 Same bytes with BIG_ENDIAN=0 -> data_o=0x34127856.
REQ-027 ready_i=0 with 8 bytes 0x01..0x08 sent back-to-back -> data_o holds 0x01020304, the second frame is dropped, and overrun_o=1; after ready_i=1, merge_finished_o drops.
REQ-028 rst pulsed after 2 bytes, then 0xAA,0xBB,0xCC,0xDD sent -> data_o=0xAABBCCDD, with no stale bytes.
REQ-029 With the macro, TIMEOUT_CYCLES=16, 3 bytes sent, then idle for 16 cycles -> sync_err_o pulses once; the next 4 bytes 0x11,0x22,0x33,0x44 -> data_o=0x11223344.
REQ-030 CHANNELS=4, WIDTH=8, bytes 0x80,0x7F,0x00,0xFF -> data_o=0x807F00FF after 4 accepted bytes, and valid_i gaps of 0..3 cycles do not change the result.
